serial_tx_buffer: RTL and testbench
===================================

Name: serial_tx_buffer

Overview:
- Transmit-side buffer between the CPU memory-mapped serial data register and the external UART chip on the shared 8-bit RAM1 data bus.
- CPU store bytes are pushed into a FIFO; a drain FSM arbitrates for the RAM1 bus, strobes `wrn`, and waits on the UART `tbre`/`tsre` handshake before sending the next byte.
- Decouples CPU store timing from UART line rate. Exposes full/empty status for the serial status word.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, pointer width; equals log2(DEPTH).
- WR_PULSE, 2, cycles `wrn` is held low; at least 1.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst, in, 1, synchronous active-low reset.
- wr_en, in, 1, one-cycle push strobe (CPU write to serial data address).
- wr_data, in, 8, byte to push (low byte of store data).
- full, out, 1, FIFO holds DEPTH entries.
- empty, out, 1, FIFO holds 0 entries and no byte is in flight.
- count, out, AW+1, number of entries currently stored.
- overflow, out, 1, sticky flag: a push was dropped.
- clr_ovf, in, 1, clears `overflow`.
- bus_req, out, 1, request for the RAM1 data bus.
- bus_grant, in, 1, bus owner grants the bus; RAM1 is disabled while granted.
- data_out, out, 8, byte driven onto the RAM1 data bus.
- data_oe, out, 1, tri-state enable for `data_out`.
- wrn, out, 1, UART write strobe, active-low.
- tbre, in, 1, UART transmit buffer empty.
- tsre, in, 1, UART transmit shift register empty.

Behaviour:
- Reset (rst=0 at an edge): pointers=0, count=0, overflow=0, state=IDLE, bus_req=0, data_oe=0, data_out=0, wrn=1. A reset taken mid-transfer abandons the byte with no extra `wrn` edge; `wrn` is high the cycle after the reset edge.
- Push:
  - wr_en=1 and not full: store `wr_data` at wptr, wptr+1 modulo DEPTH, count+1.
  - wr_en=1 and full: byte dropped, overflow<=1.
  - clr_ovf and a dropping push in the same cycle: overflow=1 (set wins).
- Pop: occurs on the SETUP->STROBE transition; rptr+1 modulo DEPTH, count-1.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - A push into a full FIFO in the same cycle as a pop is accepted, because full is evaluated before the pop.
- `full` = (count==DEPTH). `empty` = (count==0 && state==IDLE). Both are registered-state derived, with no combinational path from `wr_en`.
- FSM:
  - IDLE: if count>0, go to REQ and set bus_req=1.
  - REQ: bus_req=1; wait for bus_grant=1, then go to SETUP.
  - SETUP: data_out=mem[rptr], data_oe=1, wrn=1 for one cycle. Then go to STROBE and pop.
  - STROBE: wrn=0, data_oe=1 for WR_PULSE cycles (counter). Then go to HOLD.
  - HOLD: wrn=1, data_oe=1 for one cycle (data hold after the rising edge of `wrn`). Then go to WAIT_TBRE; bus_req=0, data_oe=0.
  - WAIT_TBRE: wait for tbre=1, then go to WAIT_TSRE.
  - WAIT_TSRE: wait for tsre=1, then go to IDLE.
- bus_req stays 1 from REQ through HOLD.
- If bus_grant drops during SETUP, STROBE or HOLD, the FSM completes the sequence anyway; the bus owner must not revoke mid-cycle.
- Latency: first `wrn` falling edge occurs 3 cycles after the push edge when bus_grant is already 1 (push -> IDLE sees count -> REQ -> SETUP -> STROBE).
- Back-to-back bytes are serialized by tbre/tsre; there is no pipelining across UART handshakes.
- Pointers wrap naturally at DEPTH. The storage array is not reset; only pointers are.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, REQ, SETUP, STROBE, HOLD, WAIT_TBRE, WAIT_TSRE);
  - the serial data and status address constants used by the decode feeding `wr_en`;
  - UART status bit positions (full and empty mapped into the status word).
- One sub-module, `sync_fifo_8` (storage, pointers, count, full); the FSM stays in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wr_en=1 -> count=0, wrn=1, data_oe=0, bus_req=0, empty=1.
- Single byte: push 0x41 with bus_grant=1, tbre=tsre=1 -> `wrn` low for exactly 2 cycles starting 3 cycles after the push; data_out=0x41 with data_oe=1 from SETUP through HOLD; empty=1 after WAIT_TSRE.
- Handshake gating: push 0x0A,0x0D; hold tbre=0 for 20 cycles after the first strobe -> no second `wrn` fall until tbre=1 and tsre=1; bytes arrive in order 0x0A then 0x0D.
- Fill and overflow: bus_grant=0, push 17 bytes 0x00..0x10 -> full=1, count=16, overflow=1, 0x10 dropped. Pulse clr_ovf -> overflow=0. Grant the bus -> 0x00..0x0F drained in order; pointer wrap is exercised.
- Simultaneous: when full, push 0x55 in the SETUP->STROBE pop cycle -> accepted, count stays 16, overflow stays 0, 0x55 is the last byte out.
- Mid-transfer reset: assert rst=0 while in STROBE -> next cycle wrn=1, data_oe=0, count=0; no further `wrn` pulses.

Source files
------------

// File: rtl/serial_tx_buffer_pkg.sv
// Shared definitions for the serial transmit buffer: drain FSM states,
// CPU address map for the serial port, and serial status word layout.
package serial_tx_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    SETUP     = 3'd2,
    STROBE    = 3'd3,
    HOLD      = 3'd4,
    WAIT_TBRE = 3'd5,
    WAIT_TSRE = 3'd6
  } tx_state_e;

  localparam logic [31:0] SERIAL_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] SERIAL_STAT_ADDR = 32'hBFD0_03FC;

  localparam int STAT_TX_EMPTY_BIT = 0;
  localparam int STAT_TX_FULL_BIT  = 2;

  // Builds the transmit half of the serial status word read by the CPU.
  function automatic logic [31:0] pack_tx_status(input logic full, input logic empty);
    logic [31:0] word;
    word = '0;
    word[STAT_TX_EMPTY_BIT] = empty;
    word[STAT_TX_FULL_BIT]  = full;
    return word;
  endfunction

endpackage

// File: rtl/serial_tx_buffer_sync_fifo_8.sv
// Byte-wide synchronous FIFO holding queued transmit bytes; storage is not
// reset, only pointers and count.
module sync_fifo_8
  import serial_tx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          dropped
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          accept;

  // A push into a full FIFO still lands when the same edge pops a slot free.
  assign full    = (count == (AW+1)'(DEPTH));
  assign accept  = push && (!full || pop);
  assign dropped = push && full && !pop;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !accept) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_buffer.sv
// Transmit buffer between CPU serial stores and the UART on the shared RAM1
// bus: queues bytes and drains them one at a time through the wrn handshake.
module serial_tx_buffer
  import serial_tx_buffer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int WR_PULSE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wrn,
  input  logic        tbre,
  input  logic        tsre
);

  localparam int PW = $clog2(WR_PULSE) + 1;

  tx_state_e     state;
  logic [PW-1:0] pulse_cnt;
  logic [7:0]    fifo_rd;
  logic          pop;
  logic          dropped;

  assign pop   = (state == SETUP);
  assign empty = (count == '0) && (state == IDLE);

  sync_fifo_8 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd),
    .count   (count),
    .full    (full),
    .dropped (dropped)
  );

  // Once SETUP is reached the sequence runs to completion regardless of bus_grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      bus_req   <= 1'b0;
      data_oe   <= 1'b0;
      data_out  <= '0;
      wrn       <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      if (dropped) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= REQ;
            bus_req <= 1'b1;
          end
        end
        REQ: begin
          if (bus_grant) begin
            state    <= SETUP;
            data_out <= fifo_rd;
            data_oe  <= 1'b1;
            wrn      <= 1'b1;
          end
        end
        SETUP: begin
          state     <= STROBE;
          wrn       <= 1'b0;
          pulse_cnt <= '0;
        end
        STROBE: begin
          if (pulse_cnt == PW'(WR_PULSE - 1)) begin
            state <= HOLD;
            wrn   <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        HOLD: begin
          state   <= WAIT_TBRE;
          bus_req <= 1'b0;
          data_oe <= 1'b0;
        end
        WAIT_TBRE: begin
          if (tbre) begin
            state <= WAIT_TSRE;
          end
        end
        WAIT_TSRE: begin
          if (tsre) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          data_oe <= 1'b0;
          wrn     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Self-checking bench for serial_tx_buffer: table-driven fill/overflow vectors,
// hand sequences for timing corners, and a byte-order scoreboard on wrn strobes.
module tb_serial_tx_buffer;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int WR_PULSE = 2;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        wr_en     = 1'b0;
  logic [7:0]  wr_data   = 8'h00;
  logic        clr_ovf   = 1'b0;
  logic        bus_grant = 1'b0;
  logic        tbre      = 1'b1;
  logic        tsre      = 1'b1;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        bus_req;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        wrn;

  int          n_cmp        = 0;
  int          n_fail       = 0;
  int          strobe_count = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  sb_byte;
  logic        prev_wrn     = 1'b1;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       accept;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[DEPTH + 2];

  serial_tx_buffer #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .WR_PULSE (WR_PULSE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .wrn       (wrn),
    .tbre      (tbre),
    .tsre      (tsre)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_en   = v.wr_en;
    wr_data = v.wr_data;
    clr_ovf = v.clr_ovf;
    if (v.accept) exp_q.push_back(v.wr_data);
    step();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int i;
    i = 0;
    while (strobe_count < target && i < budget) begin
      step();
      i++;
    end
    checkOutput("strobe_wait_count", strobe_count, target);
  endtask

  task automatic wait_empty(input int budget);
    int i;
    i = 0;
    while (empty !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    checkOutput("empty_after_drain", empty, 1);
  endtask

  // Scoreboard: each falling edge of wrn must present the oldest queued byte.
  always @(negedge clk) begin
    if (prev_wrn === 1'b1 && wrn === 1'b0) begin
      strobe_count++;
      checkOutput("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        sb_byte = exp_q.pop_front();
        checkOutput("strobe_data", data_out, sb_byte);
        checkOutput("strobe_oe", data_oe, 1);
      end
    end
    prev_wrn = wrn;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int i;
    int exp_wrn[8];
    int exp_oe[8];
    int exp_req[8];

    // Fill/overflow vectors: 17 pushes with the bus withheld, then clear overflow.
    for (int k = 0; k <= DEPTH; k++) begin
      vecs[k].wr_en     = 1'b1;
      vecs[k].wr_data   = 8'(k);
      vecs[k].clr_ovf   = 1'b0;
      vecs[k].accept    = (k < DEPTH);
      vecs[k].exp_count = (k + 1 < DEPTH) ? k + 1 : DEPTH;
      vecs[k].exp_full  = (k >= DEPTH - 1);
      vecs[k].exp_empty = 1'b0;
      vecs[k].exp_ovf   = (k == DEPTH);
    end
    vecs[DEPTH+1].wr_en     = 1'b0;
    vecs[DEPTH+1].wr_data   = 8'h00;
    vecs[DEPTH+1].clr_ovf   = 1'b1;
    vecs[DEPTH+1].accept    = 1'b0;
    vecs[DEPTH+1].exp_count = DEPTH;
    vecs[DEPTH+1].exp_full  = 1'b1;
    vecs[DEPTH+1].exp_empty = 1'b0;
    vecs[DEPTH+1].exp_ovf   = 1'b0;

    exp_wrn = '{1, 1, 0, 0, 1, 1, 1, 1};
    exp_oe  = '{0, 1, 1, 1, 1, 0, 0, 0};
    exp_req = '{1, 1, 1, 1, 1, 0, 0, 0};

    $display("[TB] reset with wr_en held high");
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    step(2);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_wrn", wrn, 1);
    checkOutput("reset_data_oe", data_oe, 0);
    checkOutput("reset_bus_req", bus_req, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_overflow", overflow, 0);
    wr_en = 1'b0;
    rst   = 1'b1;
    step();

    $display("[TB] single byte timing");
    bus_grant = 1'b1;
    tbre      = 1'b1;
    tsre      = 1'b1;
    push_byte(8'h41);
    checkOutput("single_count_after_push", count, 1);
    checkOutput("single_empty_after_push", empty, 0);
    for (int c = 0; c < 8; c++) begin
      step();
      checkOutput($sformatf("single_wrn_c%0d", c + 1), wrn, exp_wrn[c]);
      checkOutput($sformatf("single_oe_c%0d", c + 1), data_oe, exp_oe[c]);
      checkOutput($sformatf("single_req_c%0d", c + 1), bus_req, exp_req[c]);
      if (exp_oe[c] == 1) checkOutput($sformatf("single_data_c%0d", c + 1), data_out, 8'h41);
    end
    checkOutput("single_empty_end", empty, 1);
    checkOutput("single_strobes", strobe_count, 1);

    $display("[TB] handshake gating");
    tbre = 1'b0;
    tsre = 1'b0;
    base = strobe_count;
    push_byte(8'h0A);
    push_byte(8'h0D);
    wait_strobes(base + 1, 10);
    step(20);
    checkOutput("gate_tbre_low", strobe_count, base + 1);
    tbre = 1'b1;
    step(10);
    checkOutput("gate_tsre_low", strobe_count, base + 1);
    tsre = 1'b1;
    wait_strobes(base + 2, 10);
    wait_empty(20);

    $display("[TB] fill and overflow table");
    bus_grant = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("fill_count_%0d", k), count, vecs[k].exp_count);
      checkOutput($sformatf("fill_full_%0d", k), full, vecs[k].exp_full);
      checkOutput($sformatf("fill_empty_%0d", k), empty, vecs[k].exp_empty);
      checkOutput($sformatf("fill_ovf_%0d", k), overflow, vecs[k].exp_ovf);
    end
    base      = strobe_count;
    bus_grant = 1'b1;
    wait_strobes(base + DEPTH, DEPTH * 15);
    wait_empty(20);
    checkOutput("fill_drain_count", count, 0);

    $display("[TB] push on pop cycle while full");
    bus_grant = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_byte(8'(8'h80 + k));
    checkOutput("simul_full_before", full, 1);
    base      = strobe_count;
    bus_grant = 1'b1;
    step();
    checkOutput("simul_in_setup_oe", data_oe, 1);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    exp_q.push_back(8'h55);
    step();
    wr_en = 1'b0;
    checkOutput("simul_count", count, DEPTH);
    checkOutput("simul_full", full, 1);
    checkOutput("simul_overflow", overflow, 0);
    wait_strobes(base + DEPTH + 1, (DEPTH + 1) * 15);
    wait_empty(20);
    checkOutput("simul_queue_drained", exp_q.size(), 0);

    $display("[TB] reset during strobe");
    push_byte(8'h77);
    push_byte(8'h78);
    i = 0;
    while (wrn !== 1'b0 && i < 10) begin
      step();
      i++;
    end
    checkOutput("midreset_reached_strobe", wrn, 0);
    checkOutput("midreset_count_before", count, 1);
    rst = 1'b0;
    step();
    checkOutput("midreset_wrn", wrn, 1);
    checkOutput("midreset_data_oe", data_oe, 0);
    checkOutput("midreset_count", count, 0);
    checkOutput("midreset_bus_req", bus_req, 0);
    rst = 1'b1;
    exp_q.delete();
    base = strobe_count;
    step(20);
    checkOutput("midreset_no_more_strobes", strobe_count, base);
    checkOutput("midreset_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
